// File: rtl/jpeg_enc_pkg.sv
// Shared definitions for the JPEG encoder entropy path: bit packer FSM states,
// marker constants and the code-length mask helper.
package jpeg_enc_pkg;

  typedef enum logic [2:0] {
    S_RUN,
    S_STUFF,
    S_PAD,
    S_EOI1,
    S_EOI2,
    S_DONE
  } bp_state_e;

  localparam logic [7:0] JPEG_MARKER_PREFIX = 8'hFF;
  localparam logic [7:0] JPEG_EOI           = 8'hD9;

  // Mask keeping the low 'len' bits of a right-aligned code (len 0..32).
  function automatic logic [31:0] code_mask(input logic [5:0] len);
    if (len >= 6'd32) begin
      return 32'hFFFF_FFFF;
    end
    return (32'd1 << len) - 32'd1;
  endfunction

endpackage

// File: rtl/jpeg_bitpacker_ostage.sv
// Output byte register with valid/last handshake. The byte is held unchanged
// until accepted; empty_o is a registered flag the packer core combines with
// the sink's accept to decide whether a new byte may be loaded.
module jpeg_bitpacker_ostage
  import jpeg_enc_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clear_i,
  input  logic       load_i,
  input  logic [7:0] load_data_i,
  input  logic       load_last_i,
  input  logic       accept_i,
  output logic       empty_o,
  output logic       valid_o,
  output logic [7:0] data_o,
  output logic       last_o
);

  logic       valid_q;
  logic [7:0] data_q;
  logic       last_q;

  // Load a new byte when the core offers one, otherwise retire the held byte on accept.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      valid_q <= 1'b0;
      data_q  <= 8'h00;
      last_q  <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= load_data_i;
      last_q  <= load_last_i;
    end else if (accept_i) begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end
  end

  assign empty_o = ~valid_q;
  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign last_o  = last_q;

endmodule

// File: rtl/jpeg_bitpacker.sv
// JPEG entropy bit packer: packs right-aligned 0..32 bit codes MSB-first into
// bytes, pads the final byte with 1s and appends the EOI marker.
// Build option: JPEG_BITPACKER_STUFF_EN inserts 0x00 after every 0xFF data or
// pad byte; without it data bytes are emitted raw. EOI is the same either way.
//
// state    | meaning
// S_RUN    | accepting codes, emitting whole bytes
// S_STUFF  | emit 0x00 after a 0xFF byte, then return to saved state
// S_PAD    | last code seen: drain whole bytes, then the 1-padded tail
// S_EOI1   | emit 0xFF marker prefix (never stuffed)
// S_EOI2   | emit 0xD9 with last flag
// S_DONE   | idle until rst_i or img_start_i
module jpeg_bitpacker
  import jpeg_enc_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        img_start_i,
  input  logic        inport_valid_i,
  input  logic [31:0] inport_data_i,
  input  logic [5:0]  inport_len_i,
  input  logic        inport_last_i,
  output logic        ready_o,
  output logic        outport_valid_o,
  output logic [7:0]  outport_data_o,
  output logic        outport_last_o,
  input  logic        outport_accept_i
);

  bp_state_e   state_q, state_d;
  logic [63:0] acc_q, acc_d, base_acc;
  logic [6:0]  count_q, count_d, base_cnt, shamt;
  logic [31:0] code;
  logic        push, pop, pad, free, ost_empty;
  logic        load, load_last;
  logic [7:0]  load_data;
`ifdef JPEG_BITPACKER_STUFF_EN
  bp_state_e   ret_q, ret_d;
`endif

  // Only registered state feeds ready_o, so sink backpressure never reaches the source combinationally.
  assign ready_o = (state_q == S_RUN) && (count_q <= 7'd32);

  // Next-state, byte selection and accumulator update.
  always_comb begin
    free      = ost_empty | outport_accept_i;
    push      = inport_valid_i & ready_o;
    code      = inport_data_i & code_mask(inport_len_i);
    state_d   = state_q;
    pop       = 1'b0;
    pad       = 1'b0;
    load      = 1'b0;
    load_data = 8'h00;
    load_last = 1'b0;
`ifdef JPEG_BITPACKER_STUFF_EN
    ret_d     = ret_q;
`endif

    case (state_q)
      S_RUN: begin
        if (free && count_q >= 7'd8) begin
          pop       = 1'b1;
          load      = 1'b1;
          load_data = acc_q[63:56];
        end
        if (push && inport_last_i) begin
          state_d = S_PAD;
        end
      end
      S_PAD: begin
        if (count_q == 7'd0) begin
          state_d = S_EOI1;
        end else if (free) begin
          load = 1'b1;
          if (count_q >= 7'd8) begin
            pop       = 1'b1;
            load_data = acc_q[63:56];
          end else begin
            // Bits below count_q are always zero, so OR-ing in ones pads the tail.
            pad       = 1'b1;
            load_data = acc_q[63:56] | (8'hFF >> count_q[2:0]);
          end
        end
      end
`ifdef JPEG_BITPACKER_STUFF_EN
      S_STUFF: begin
        if (free) begin
          load      = 1'b1;
          load_data = 8'h00;
          state_d   = ret_q;
        end
      end
`endif
      S_EOI1: begin
        if (free) begin
          load      = 1'b1;
          load_data = JPEG_MARKER_PREFIX;
          state_d   = S_EOI2;
        end
      end
      S_EOI2: begin
        if (free) begin
          load      = 1'b1;
          load_data = JPEG_EOI;
          load_last = 1'b1;
          state_d   = S_DONE;
        end
      end
      default: ;
    endcase

`ifdef JPEG_BITPACKER_STUFF_EN
    // A last code accepted alongside a 0xFF pop must resume in S_PAD, hence state_d.
    if ((pop || pad) && load_data == JPEG_MARKER_PREFIX) begin
      ret_d   = state_d;
      state_d = S_STUFF;
    end
`endif

    base_acc = acc_q;
    base_cnt = count_q;
    if (pop) begin
      base_acc = {acc_q[55:0], 8'h00};
      base_cnt = count_q - 7'd8;
    end
    if (pad) begin
      base_acc = '0;
      base_cnt = '0;
    end
    shamt   = 7'd64 - base_cnt - {1'b0, inport_len_i};
    acc_d   = base_acc;
    count_d = base_cnt;
    if (push) begin
      acc_d   = base_acc | ({32'h0, code} << shamt);
      count_d = base_cnt + {1'b0, inport_len_i};
    end
  end

  // State and accumulator registers; img_start_i restarts the image like reset.
  always_ff @(posedge clk_i) begin
    if (rst_i || img_start_i) begin
      state_q <= S_RUN;
      acc_q   <= '0;
      count_q <= '0;
`ifdef JPEG_BITPACKER_STUFF_EN
      ret_q   <= S_RUN;
`endif
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
`ifdef JPEG_BITPACKER_STUFF_EN
      ret_q   <= ret_d;
`endif
    end
  end

  jpeg_bitpacker_ostage u_ostage (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clear_i     (img_start_i),
    .load_i      (load),
    .load_data_i (load_data),
    .load_last_i (load_last),
    .accept_i    (outport_accept_i),
    .empty_o     (ost_empty),
    .valid_o     (outport_valid_o),
    .data_o      (outport_data_o),
    .last_o      (outport_last_o)
  );

endmodule

// File: tb/tb_jpeg_bitpacker.sv
// Scoreboard bench for jpeg_bitpacker: a bit-queue reference model fills the
// expected byte queue at code acceptance; a monitor pops it on each handshake.
module tb_jpeg_bitpacker;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        img_start_i = 1'b0;
  logic        inport_valid_i = 1'b0;
  logic [31:0] inport_data_i = '0;
  logic [5:0]  inport_len_i = '0;
  logic        inport_last_i = 1'b0;
  logic        ready_o;
  logic        outport_valid_o;
  logic [7:0]  outport_data_o;
  logic        outport_last_o;
  logic        outport_accept_i = 1'b1;

  jpeg_bitpacker dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .img_start_i      (img_start_i),
    .inport_valid_i   (inport_valid_i),
    .inport_data_i    (inport_data_i),
    .inport_len_i     (inport_len_i),
    .inport_last_i    (inport_last_i),
    .ready_o          (ready_o),
    .outport_valid_o  (outport_valid_o),
    .outport_data_o   (outport_data_o),
    .outport_last_o   (outport_last_o),
    .outport_accept_i (outport_accept_i)
  );

  initial forever #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [8:0]  exp_q[$];
  bit          bitq[$];
  int          out_cyc[$];
  int          acc_mode = 1;
  int          acc_cyc = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic void emit_from_bits();
    logic [7:0] b;
    for (int i = 7; i >= 0; i--) b[i] = bitq.pop_front();
    exp_q.push_back({1'b0, b});
`ifdef JPEG_BITPACKER_STUFF_EN
    if (b == 8'hFF) exp_q.push_back(9'h000);
`endif
  endfunction

  function automatic void model_push(input logic [31:0] d, input logic [5:0] l, input logic lst);
    for (int i = int'(l) - 1; i >= 0; i--) bitq.push_back(d[i]);
    while (bitq.size() >= 8) emit_from_bits();
    if (lst) begin
      if (bitq.size() > 0) begin
        while (bitq.size() < 8) bitq.push_back(1'b1);
        emit_from_bits();
      end
      exp_q.push_back({1'b0, 8'hFF});
      exp_q.push_back({1'b1, 8'hD9});
    end
  endfunction

  task automatic monitor();
    bit         hold_pend = 0;
    logic [7:0] hold_data = 0;
    logic [8:0] e;
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        hold_pend = 0;
      end else begin
        if (hold_pend) check("held_byte", {outport_valid_o, outport_data_o}, {1'b1, hold_data});
        if (outport_valid_o && outport_accept_i) begin
          out_cyc.push_back(cyc);
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_byte: got %0h expected none", outport_data_o);
          end else begin
            e = exp_q.pop_front();
            check("out_byte{last,data}", {outport_last_o, outport_data_o}, e);
          end
        end
        hold_pend = outport_valid_o && !outport_accept_i && !img_start_i;
        hold_data = outport_data_o;
      end
    end
  endtask

  task automatic acc_drv();
    forever begin
      @(posedge clk_i);
      #1;
      case (acc_mode)
        0:       outport_accept_i = 1'b0;
        1:       outport_accept_i = 1'b1;
        default: outport_accept_i = 1'($urandom_range(0, 1));
      endcase
    end
  endtask

  // Called just after a rising edge; returns just after the edge that took the code.
  task automatic push(input logic [31:0] d, input logic [5:0] l, input logic lst);
    int t = 0;
    bit done = 0;
    inport_valid_i = 1'b1;
    inport_data_i  = d;
    inport_len_i   = l;
    inport_last_i  = lst;
    while (!done) begin
      @(negedge clk_i);
      if (ready_o) begin
        model_push(d, l, lst);
        acc_cyc = cyc;
        done = 1;
      end else if (++t > 500) begin
        n_cmp++;
        n_err++;
        $display("FAIL push_timeout: got ready_o=0 for %0d cycles expected 1", t);
        done = 1;
      end
      @(posedge clk_i);
      #1;
    end
    inport_valid_i = 1'b0;
    inport_last_i  = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || outport_valid_o) && t < 3000) begin
      @(negedge clk_i);
      t++;
    end
    if (t >= 3000) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: got %0d bytes left expected 0", exp_q.size());
    end
    repeat (4) @(negedge clk_i);
    check("drained", exp_q.size(), 0);
    @(posedge clk_i);
    #1;
  endtask

  task automatic restart();
    img_start_i = 1'b1;
    @(posedge clk_i);
    #1;
    img_start_i = 1'b0;
    exp_q.delete();
    bitq.delete();
  endtask

  initial begin
    int first_acc;
    int npush;
    int n;
    logic [31:0] d;

    fork
      monitor();
      acc_drv();
    join_none

    repeat (3) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    check("rst_valid", outport_valid_o, 0);
    check("rst_data", outport_data_o, 0);
    check("rst_last", outport_last_o, 0);
    check("rst_ready", ready_o, 1);
    @(posedge clk_i);
    #1;

    // Two bytes back to back; first one two cycles after acceptance.
    out_cyc.delete();
    push(32'h0000_00A5, 6'd8, 1'b0);
    first_acc = acc_cyc;
    push(32'hFFFF_FF3C, 6'd8, 1'b0);
    drain();
    check("n_out", out_cyc.size(), 2);
    if (out_cyc.size() >= 2) begin
      check("latency", out_cyc[0] - first_acc, 2);
      check("back_to_back", out_cyc[1] - out_cyc[0], 1);
    end
    restart();

    // 0xFF data byte (stuffed with the macro defined)
    push(32'h0000_00FF, 6'd8, 1'b0);
    drain();
    restart();

    // 3-bit tail padded with ones, then EOI
    push(32'h0000_0005, 6'd3, 1'b1);
    drain();
    @(negedge clk_i);
    check("done_ready", ready_o, 0);
    repeat (3) @(negedge clk_i);
    check("done_no_output", outport_valid_o, 0);
    @(posedge clk_i);
    #1;
    restart();

    // pad byte becomes 0xFF
    push(32'h0000_000F, 6'd4, 1'b1);
    drain();
    restart();

    // Backpressure: fill until ready_o drops, then release.
    acc_mode = 0;
    repeat (3) @(posedge clk_i);
    #1;
    npush = 0;
    for (int i = 0; i < 8; i++) begin
      d = $urandom;
      inport_valid_i = 1'b1;
      inport_data_i  = d;
      inport_len_i   = 6'd32;
      inport_last_i  = 1'b0;
      @(negedge clk_i);
      if (!ready_o) break;
      model_push(d, 6'd32, 1'b0);
      npush++;
      @(posedge clk_i);
      #1;
    end
    inport_valid_i = 1'b0;
    @(posedge clk_i);
    #1;
    check("bp_pushes", npush, 2);
    repeat (5) @(posedge clk_i);
    @(negedge clk_i);
    check("bp_ready_low", ready_o, 0);
    check("bp_valid_held", outport_valid_o, 1);
    @(posedge clk_i);
    #1;
    acc_mode = 1;
    drain();
    restart();

    // img_start with pending bytes
    acc_mode = 0;
    push(32'h0000_0077, 6'd8, 1'b0);
    push(32'h0000_0055, 6'd8, 1'b0);
    repeat (4) @(posedge clk_i);
    #1;
    restart();
    @(negedge clk_i);
    check("imgstart_valid", outport_valid_o, 0);
    check("imgstart_ready", ready_o, 1);
    @(posedge clk_i);
    #1;
    acc_mode = 1;
    push(32'h0000_0012, 6'd8, 1'b0);
    drain();
    restart();

    // Random images with random lengths, garbage upper bits and random accept.
    for (int img = 0; img < 8; img++) begin
      acc_mode = (img % 3 == 0) ? 1 : 2;
      n = $urandom_range(1, 24);
      for (int k = 0; k < n; k++) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk_i);
          #1;
        end
        push($urandom, 6'($urandom_range(0, 32)), k == n - 1);
      end
      acc_mode = 1;
      drain();
      restart();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
